// File: rtl/inst_mem_loadable.sv
// Loadable instruction memory: program streamed in over a valid/ready port,
// then served to the fetch stage with one cycle of latency.
module inst_mem_loadable #(
    parameter int            IW  = 10,
    parameter int            DW  = 9,
    parameter logic [DW-1:0] NOP = '0
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          LoadStart,
    input  logic [IW:0]   LoadLen,
    input  logic [DW-1:0] LoadData,
    input  logic          LoadValid,
    output logic          LoadReady,
    output logic          LoadDone,
    output logic          LoadErr,
    output logic [DW-1:0] LoadSum,
    output logic          Running,
    input  logic          FetchReq,
    input  logic [IW-1:0] FetchAddr,
    output logic [DW-1:0] InstOut,
    output logic          InstValid,
    output logic          FetchOob
);
    localparam int          DEPTH  = 1 << IW;
    localparam logic [IW:0] MAXLEN = (IW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t        r_state;
    logic [DW-1:0] r_mem [DEPTH];
    logic [IW-1:0] r_count;
    logic [IW:0]   r_len;
    logic          r_ready, r_done, r_err, r_running, r_ivalid, r_oob;
    logic [DW-1:0] r_sum, r_inst;

    logic w_start_ok, w_accept, w_last, w_oob;

    assign w_start_ok = LoadStart && (r_state != LOAD) &&
                        (LoadLen != '0) && (LoadLen <= MAXLEN);
    assign w_accept   = r_ready && LoadValid;
    // Count is IW bits, so a full-depth load wraps to 0 exactly on its last accept.
    assign w_last     = ({1'b0, r_count} == (r_len - (IW+1)'(1)));
    assign w_oob      = ({1'b0, FetchAddr} >= r_len);

    always_ff @(posedge Clk) begin
        if (w_accept)
            r_mem[r_count] <= LoadData;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state   <= IDLE;
            r_ready   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_running <= 1'b0;
            r_sum     <= '0;
            r_count   <= '0;
            r_len     <= '0;
            r_inst    <= '0;
            r_ivalid  <= 1'b0;
            r_oob     <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_ivalid <= 1'b0;
            r_oob    <= 1'b0;
            case (r_state)
                IDLE, RUN: begin
                    if (w_start_ok) begin
                        r_state   <= LOAD;
                        r_ready   <= 1'b1;
                        r_running <= 1'b0;
                        r_count   <= '0;
                        r_sum     <= '0;
                        r_len     <= LoadLen;
                    end else if (LoadStart) begin
                        r_err <= 1'b1;
                    end
                    // An accepted load pre-empts a fetch issued in the same cycle.
                    if (r_state == RUN && FetchReq && !w_start_ok) begin
                        r_ivalid <= 1'b1;
                        r_oob    <= w_oob;
                        r_inst   <= w_oob ? NOP : r_mem[FetchAddr];
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_sum   <= r_sum ^ LoadData;
                        r_count <= r_count + IW'(1);
                        if (w_last) begin
                            r_state   <= RUN;
                            r_ready   <= 1'b0;
                            r_running <= 1'b1;
                            r_done    <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_ready   <= 1'b0;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign LoadReady = r_ready;
    assign LoadDone  = r_done;
    assign LoadErr   = r_err;
    assign LoadSum   = r_sum;
    assign Running   = r_running;
    assign InstOut   = r_inst;
    assign InstValid = r_ivalid;
    assign FetchOob  = r_oob;
endmodule
